// File: rtl/ram_arbiter.sv
// Shares one synchronous-read RAM port between m0 (fixed priority) and m1 (starvation-guarded).
// Grant is combinational with zero latency, read data returns one cycle later, and a denied master holds its request.
module ram_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [3:0]    m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [3:0]    m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_ren,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          rd_pend;
  logic          rd_owner;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!rst) begin
      if (m1_req && starve_cnt == CW'(STARVE_MAX)) m1_gnt = 1'b1;
      else if (m0_req)                             m0_gnt = 1'b1;
      else if (m1_req)                             m1_gnt = 1'b1;
    end
  end

  always_comb begin
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (m0_gnt) begin
      ram_wen   = m0_wen;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_wen   = m1_wen;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
    end
    ram_ren = (m0_gnt || m1_gnt) && (ram_wen == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rd_pend <= ram_ren;
      if (ram_ren) rd_owner <= m1_gnt;
      if (m1_gnt || !m1_req)
        starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX))
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Gating with rst drops the return of a read granted just before reset.
  assign m0_rvalid = rd_pend && !rd_owner && !rst;
  assign m1_rvalid = rd_pend &&  rd_owner && !rst;
  assign m0_rdata  = m0_rvalid ? ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [3:0]    m0_wen, m1_wen, ram_wen;
  logic [AW-1:0] m0_addr, m1_addr, ram_addr;
  logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic          ram_ren;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [64];
  logic [31:0] sb_mem [64];
  logic        l_ren   = 1'b0;
  logic [3:0]  l_wen   = 4'h0;
  logic [31:0] l_addr  = '0;
  logic [31:0] l_wdata = '0;

  ram_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: port signals are latched mid-cycle, applied on the rising edge.
  always @(negedge clk) begin
    l_ren   = ram_ren;
    l_wen   = ram_wen;
    l_addr  = ram_addr;
    l_wdata = ram_wdata;
  end

  always @(posedge clk) begin
    if (l_ren) ram_rdata = mem[l_addr[7:2]];
    for (int b = 0; b < 4; b++)
      if (l_wen[b]) mem[l_addr[7:2]][8*b +: 8] = l_wdata[8*b +: 8];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m0_req = 1'b0; m0_wen = 4'h0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wen = 4'h0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h10;
    m1_req = 1'b1; m1_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: gnt=%b%b ren=%b wen=%h addr=%h rv=%b%b, required all zero",
               m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, m0_rvalid, m1_rvalid);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== '0) begin
      bad++;
      $display("FAIL post_reset_outputs: gnt=%b%b ren=%b rv=%b%b, required all zero",
               m0_gnt, m1_gnt, ram_ren, m0_rvalid, m1_rvalid);
    end
    total++;
    if (dut.starve_cnt !== '0) begin
      bad++;
      $display("FAIL reset_starve_cnt: got %0d required 0", dut.starve_cnt);
    end
    step();
  endtask

  task automatic test_m0_read;
    mem[4] = 32'hDEADBEEF; sb_mem[4] = 32'hDEADBEEF;
    m0_req = 1'b1; m0_wen = 4'h0; m0_addr = 32'h10;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr} !== {1'b1, 1'b0, 1'b1, 4'h0, 32'h10}) begin
      bad++;
      $display("FAIL m0_read_issue: gnt=%b%b ren=%b wen=%h addr=%h, required 10 1 0 00000010",
               m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF, 32'h0}) begin
      bad++;
      $display("FAIL m0_read_return: rv=%b%b rdata0=%h rdata1=%h, required 10 deadbeef 00000000",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    step();
  endtask

  task automatic test_contention;
    mem[16] = 32'h40404040; sb_mem[16] = 32'h40404040;
    m0_req = 1'b1; m0_wen = 4'b0011; m0_addr = 32'h20; m0_wdata = 32'h1234;
    m1_req = 1'b1; m1_wen = 4'b0000; m1_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata} !== {1'b1, 1'b0, 1'b0, 4'b0011, 32'h20, 32'h1234}) begin
      bad++;
      $display("FAIL contention_m0_write: gnt=%b%b ren=%b wen=%b addr=%h wdata=%h, required 10 0 0011 20 1234",
               m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata);
    end
    sb_mem[8][15:0] = 16'h1234;
    step();
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, ram_addr, m0_rvalid, m1_rvalid} !== {1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL contention_m1_next: gnt=%b%b ren=%b addr=%h rv=%b%b, required 01 1 40 00",
               m0_gnt, m1_gnt, ram_ren, ram_addr, m0_rvalid, m1_rvalid);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid, m1_rdata} !== {1'b0, 1'b1, 32'h40404040}) begin
      bad++;
      $display("FAIL contention_m1_return: rv=%b%b rdata1=%h, required 01 40404040",
               m0_rvalid, m1_rvalid, m1_rdata);
    end
    step();
  endtask

  task automatic test_starvation;
    m0_req = 1'b1; m0_addr = 32'h0;
    m1_req = 1'b1; m1_addr = 32'h4;
    for (int c = 0; c <= SM; c++) begin
      @(negedge clk);
      total++;
      if ({m0_gnt, m1_gnt} !== ((c < SM) ? 2'b10 : 2'b01)) begin
        bad++;
        $display("FAIL starve_cycle%0d: gnt=%b%b required %b", c, m0_gnt, m1_gnt,
                 (c < SM) ? 2'b10 : 2'b01);
      end
      step();
    end
    m1_req = 1'b0;
    @(negedge clk);
    total++;
    if ({dut.starve_cnt, m0_gnt} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL starve_after: cnt=%0d m0_gnt=%b, required 0 1", dut.starve_cnt, m0_gnt);
    end
    step();
    idle_inputs();
    step();
  endtask

  task automatic test_interleave;
    mem[0] = 32'h0BADF00D; sb_mem[0] = 32'h0BADF00D;
    mem[1] = 32'hCAFEBABE; sb_mem[1] = 32'hCAFEBABE;
    m0_req = 1'b1; m0_addr = 32'h0;
    step();
    m0_req = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h4;
    @(negedge clk);
    total++;
    if ({m1_gnt, ram_addr, m0_rvalid, m1_rvalid, m0_rdata} !== {1'b1, 32'h4, 1'b1, 1'b0, 32'h0BADF00D}) begin
      bad++;
      $display("FAIL interleave_c1: m1_gnt=%b addr=%h rv=%b%b rdata0=%h, required 1 4 10 0badf00d",
               m1_gnt, ram_addr, m0_rvalid, m1_rvalid, m0_rdata);
    end
    step();
    idle_inputs();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== {1'b0, 1'b1, 32'h0, 32'hCAFEBABE}) begin
      bad++;
      $display("FAIL interleave_c2: rv=%b%b rdata0=%h rdata1=%h, required 01 0 cafebabe",
               m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_read;
    m0_req = 1'b1; m0_addr = 32'h10;
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_issue: m0_gnt=%b required 1", m0_gnt);
    end
    step();
    rst = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h8;
    @(negedge clk);
    total++;
    if ({m0_gnt, m1_gnt, ram_ren, m0_rvalid, m1_rvalid, m0_rdata} !== '0) begin
      bad++;
      $display("FAIL midrst_during: gnt=%b%b ren=%b rv=%b%b, required all zero",
               m0_gnt, m1_gnt, ram_ren, m0_rvalid, m1_rvalid);
    end
    step();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++;
    if ({m0_rvalid, m1_rvalid, m0_rdata, dut.starve_cnt} !== '0) begin
      bad++;
      $display("FAIL midrst_after: rv=%b%b rdata0=%h cnt=%0d, required all zero",
               m0_rvalid, m1_rvalid, m0_rdata, dut.starve_cnt);
    end
    step();
  endtask

  task automatic test_random;
    int          waited = 0;
    logic        pv = 1'b0, po = 1'b0;
    logic [31:0] pd = '0;
    logic        e0, e1, e0v, e1v;
    logic [3:0]  ewen;
    logic [31:0] eaddr, ewd;
    for (int i = 0; i < 64; i++) sb_mem[i] = mem[i];
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 70) == 0);
      if (!m0_req) begin
        m0_req   = ($urandom_range(0, 2) != 0);
        m0_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        m0_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m0_wdata = $urandom;
      end
      if (!m1_req) begin
        m1_req   = ($urandom_range(0, 1) == 1);
        m1_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        m1_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m1_wdata = $urandom;
      end
      @(negedge clk);
      e1    = !rst && m1_req && (waited >= SM || !m0_req);
      e0    = !rst && m0_req && !e1;
      ewen  = e0 ? m0_wen   : e1 ? m1_wen   : 4'h0;
      eaddr = e0 ? m0_addr  : e1 ? m1_addr  : 32'h0;
      ewd   = e0 ? m0_wdata : e1 ? m1_wdata : 32'h0;
      e0v   = pv && !po && !rst;
      e1v   = pv &&  po && !rst;
      total++;
      if ({m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata} !==
          {e0, e1, (e0 || e1) && ewen == 4'h0, ewen, eaddr, ewd}) begin
        bad++;
        $display("FAIL rand_issue c%0d: gnt=%b%b ren=%b wen=%h addr=%h wd=%h, required gnt=%b%b wen=%h addr=%h wd=%h",
                 c, m0_gnt, m1_gnt, ram_ren, ram_wen, ram_addr, ram_wdata, e0, e1, ewen, eaddr, ewd);
      end
      total++;
      if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !==
          {e0v, e1v, e0v ? pd : 32'h0, e1v ? pd : 32'h0}) begin
        bad++;
        $display("FAIL rand_return c%0d: rv=%b%b rd0=%h rd1=%h, required rv=%b%b data=%h",
                 c, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e0v, e1v, pd);
      end
      waited = (rst || !m1_req || e1) ? 0 : ((waited < SM) ? waited + 1 : SM);
      pv = (e0 || e1) && ewen == 4'h0;
      po = e1;
      pd = sb_mem[eaddr[7:2]];
      for (int b = 0; b < 4; b++)
        if (ewen[b]) sb_mem[eaddr[7:2]][8*b +: 8] = ewd[8*b +: 8];
      step();
      if (e0) m0_req = 1'b0;
      if (e1) m1_req = 1'b0;
    end
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hA5000000 ^ (i * 32'h01010101);
      sb_mem[i] = mem[i];
    end
    ram_rdata = '0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    test_reset();
    test_m0_read();
    test_contention();
    test_starvation();
    test_interleave();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
